// File: rtl/mbist_pkg.sv
// Shared types and March C- element tables for the MBIST controller.
// Table bit i describes element Mi.
package mbist_pkg;

  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_t;
  typedef enum logic [2:0] {IDLE, SETUP, RUN, DRAIN, DONE} state_t;

  localparam int NUM_ELEMS = 6;

  // Columns of the March C- table: {w0} {r0,w1} {r1,w0} v{r0,w1} v{r1,w0} {r0}
  localparam logic [NUM_ELEMS-1:0] ELEM_DOWN      = 6'b011000;
  localparam logic [NUM_ELEMS-1:0] ELEM_HAS_READ  = 6'b111110;
  localparam logic [NUM_ELEMS-1:0] ELEM_HAS_WRITE = 6'b011111;
  localparam logic [NUM_ELEMS-1:0] ELEM_RD_BG     = 6'b010100;
  localparam logic [NUM_ELEMS-1:0] ELEM_WR_BG     = 6'b001010;

  function automatic logic elem_two_ops(elem_t e);
    return ELEM_HAS_READ[e] & ELEM_HAS_WRITE[e];
  endfunction

  // Ops run read-then-write, so the write sits at index 1 only when a read precedes it.
  function automatic logic op_is_write(elem_t e, logic op);
    return ELEM_HAS_WRITE[e] && (op == ELEM_HAS_READ[e]);
  endfunction

  function automatic elem_t next_elem(elem_t e);
    return elem_t'(e + 3'd1);
  endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// Single-port test memory bus driven by the March engine.
interface mbist_mem_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) ();
  logic                  write_read;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output write_read, address, wdata, input rdata);
  modport slave  (input write_read, address, wdata, output rdata);
endinterface

// File: rtl/mbist_rd_cmp.sv
// Expected-data pipeline aligned to memory read latency, comparator and
// first-failure capture with a saturating mismatch counter.
module mbist_rd_cmp
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_expected,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  elem_t                 load_elem,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [CNT_WIDTH-1:0]  fail_count
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] expected;
    logic [ADDR_WIDTH-1:0] addr;
    elem_t                 elem;
  } cmp_entry_t;

  cmp_entry_t pipe [RD_LATENCY];
  cmp_entry_t tail;

  assign tail = pipe[RD_LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is a shift register, not a RAM; stale valid bits would raise false fails, so every stage is reset.
      for (int i = 0; i < RD_LATENCY; i++) pipe[i] <= '0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_count <= '0;
    end else if (clear) begin
      for (int i = 0; i < RD_LATENCY; i++) pipe[i] <= '0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_count <= '0;
    end else begin
      pipe[0] <= '{valid: load, expected: load_expected, addr: load_addr, elem: load_elem};
      for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
      if (tail.valid && (rdata != tail.expected)) begin
        if (fail_count != '1) fail_count <= fail_count + 1'b1;
        if (!fail) begin
          fail      <= 1'b1;
          fail_addr <= tail.addr;
          fail_elem <= tail.elem;
        end
      end
    end
  end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST sequencer: walks the six elements over 0..LAST_ADDR with
// registered memory-bus outputs and hands every read to the comparator.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LAST_ADDR  = 2**ADDR_WIDTH - 1,
  parameter int RD_LATENCY = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  mbist_mem_if.master           mem,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [CNT_WIDTH-1:0]  fail_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);
  localparam int DRAIN_W = $clog2(RD_LATENCY) + 1;

  state_t                state;
  elem_t                 elem;
  logic                  op;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DRAIN_W-1:0]    drain_cnt;

  function automatic logic [ADDR_WIDTH-1:0] first_addr(elem_t e);
    return ELEM_DOWN[e] ? LAST : '0;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] wr_bg(elem_t e);
    return {DATA_WIDTH{ELEM_WR_BG[e]}};
  endfunction

  logic at_end, last_op, accept;
  assign at_end  = (addr_q == (ELEM_DOWN[elem] ? '0 : LAST));
  assign last_op = !elem_two_ops(elem) || op;
  assign accept  = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      elem      <= M0;
      op        <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: state and outputs use non-blocking assignments so every register sees pre-edge values.
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= SETUP;
            elem    <= M0;
            busy    <= 1'b1;
            done    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= first_addr(M0);
            wdata_q <= wr_bg(M0);
          end
        end
        SETUP: begin
          state <= RUN;
          op    <= 1'b0;
          wr_q  <= op_is_write(elem, 1'b0);
        end
        RUN: begin
          if (!last_op) begin
            op   <= 1'b1;
            wr_q <= op_is_write(elem, 1'b1);
          end else if (!at_end) begin
            op     <= 1'b0;
            wr_q   <= op_is_write(elem, 1'b0);
            addr_q <= ELEM_DOWN[elem] ? addr_q - 1'b1 : addr_q + 1'b1;
          end else if (elem == M5) begin
            state     <= DRAIN;
            wr_q      <= 1'b0;
            drain_cnt <= '0;
          end else begin
            // wdata changes here, one cycle before the element's first write.
            state   <= SETUP;
            elem    <= next_elem(elem);
            wr_q    <= 1'b0;
            addr_q  <= first_addr(next_elem(elem));
            wdata_q <= wr_bg(next_elem(elem));
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == DRAIN_W'(RD_LATENCY - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem.write_read = wr_q;
  assign mem.address    = addr_q;
  assign mem.wdata      = wdata_q;

  mbist_rd_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RD_LATENCY (RD_LATENCY),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_rd_cmp (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (accept),
    .load          ((state == RUN) && !wr_q),
    .load_expected ({DATA_WIDTH{ELEM_RD_BG[elem]}}),
    .load_addr     (addr_q),
    .load_elem     (elem),
    .rdata         (mem.rdata),
    .fail          (fail),
    .fail_addr     (fail_addr),
    .fail_elem     (fail_elem),
    .fail_count    (fail_count)
  );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: two instances (4-word and 60-word) against
// fault-injecting memory models and a string-driven March C- reference.
module tb_mbist_march_ctrl;

  logic clk, rst_n, start_a, start_b;
  logic busy_a, done_a, fail_a, busy_b, done_b, fail_b;
  logic [1:0] fail_addr_a;
  logic [5:0] fail_addr_b;
  logic [2:0] fail_elem_a, fail_elem_b;
  logic [7:0] fail_count_a, fail_count_b;

  mbist_mem_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) mem_a_if ();
  mbist_mem_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) mem_b_if ();

  mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .LAST_ADDR(3), .RD_LATENCY(2), .CNT_WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mem(mem_a_if), .busy(busy_a), .done(done_a),
    .fail(fail_a), .fail_addr(fail_addr_a), .fail_elem(fail_elem_a), .fail_count(fail_count_a));

  mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .LAST_ADDR(59), .RD_LATENCY(2), .CNT_WIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mem(mem_b_if), .busy(busy_b), .done(done_b),
    .fail(fail_b), .fail_addr(fail_addr_b), .fail_elem(fail_elem_b), .fail_count(fail_count_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Fault kinds: 0 none, 1 word stuck-at-0, 2 one bit stuck-at-1, 3 every read inverted.
  int fa_kind = 0, fa_addr = 0, fa_bit = 0;
  int fb_kind = 0, fb_addr = 0, fb_bit = 0;

  function automatic logic [7:0] apply_fault(int kind, int faddr, int fbit, int a, logic [7:0] v);
    case (kind)
      1:       return (a == faddr) ? 8'h00 : v;
      2:       return (a == faddr) ? (v | (8'h01 << fbit)) : v;
      3:       return ~v;
      default: return v;
    endcase
  endfunction

  // Memories: wdata is registered a cycle ahead of its use; reads take two register stages.
  logic [7:0] mem_a [4];
  logic [7:0] mem_b [64];
  logic [7:0] wq_a, p_a, wq_b, p_b;

  always @(posedge clk) begin
    wq_a <= mem_a_if.wdata;
    if (mem_a_if.write_read) mem_a[mem_a_if.address] <= wq_a;
    p_a <= apply_fault(fa_kind, fa_addr, fa_bit, int'(mem_a_if.address), mem_a[mem_a_if.address]);
    mem_a_if.rdata <= p_a;
  end

  always @(posedge clk) begin
    wq_b <= mem_b_if.wdata;
    if (mem_b_if.write_read) mem_b[mem_b_if.address] <= wq_b;
    p_b <= apply_fault(fb_kind, fb_addr, fb_bit, int'(mem_b_if.address), mem_b[mem_b_if.address]);
    mem_b_if.rdata <= p_b;
  end

  // March C- as written on paper.
  string march [6] = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};
  bit march_down [6] = '{0, 0, 0, 1, 1, 0};

  function automatic void ref_run(input int kind, input int faddr, input int fbit, input int n,
                                  output int cnt, output int first_a, output int first_e);
    logic [7:0] m [64];
    logic [7:0] v, bgv;
    int a;
    cnt = 0; first_a = 0; first_e = 0;
    for (int i = 0; i < 64; i++) m[i] = 8'h00;
    for (int e = 0; e < 6; e++)
      for (int k = 0; k < n; k++) begin
        a = march_down[e] ? n - 1 - k : k;
        for (int j = 0; j < march[e].len(); j += 2) begin
          bgv = (march[e][j+1] == "1") ? 8'hFF : 8'h00;
          if (march[e][j] == "w") m[a] = bgv;
          else begin
            v = apply_fault(kind, faddr, fbit, a, m[a]);
            if (v != bgv) begin
              if (cnt == 0) begin first_a = a; first_e = e; end
              cnt++;
            end
          end
        end
      end
    if (cnt > 255) cnt = 255;
  endfunction

  typedef struct {
    bit wr;
    int addr;
    int wd;
    bit chk_wd;
  } trace_t;

  trace_t obs[$];
  trace_t expq[$];

  task automatic build_trace(input int n);
    int a, wbg;
    bit has_w;
    expq.delete();
    for (int e = 0; e < 6; e++) begin
      wbg = 0; has_w = 0;
      for (int j = 0; j < march[e].len(); j += 2)
        if (march[e][j] == "w") begin has_w = 1; wbg = (march[e][j+1] == "1") ? 255 : 0; end
      expq.push_back('{wr: 1'b0, addr: march_down[e] ? n - 1 : 0, wd: wbg, chk_wd: has_w});
      for (int k = 0; k < n; k++) begin
        a = march_down[e] ? n - 1 - k : k;
        for (int j = 0; j < march[e].len(); j += 2)
          expq.push_back('{wr: (march[e][j] == "w"), addr: a, wd: wbg, chk_wd: (march[e][j] == "w")});
      end
    end
    for (int d = 0; d < 2; d++) expq.push_back('{wr: 1'b0, addr: n - 1, wd: 0, chk_wd: 1'b0});
  endtask

  // Pulse start, then count busy cycles; optionally pulse start again at cycle inj.
  task automatic run(input int which, input int inj, input bit rec, output int cyc);
    @(negedge clk);
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    cyc = 0;
    while (((which == 0) ? busy_a : busy_b) && cyc < 2000) begin
      if (rec) obs.push_back('{wr: mem_a_if.write_read, addr: int'(mem_a_if.address),
                              wd: int'(mem_a_if.wdata), chk_wd: 1'b0});
      cyc++;
      if (which == 0) start_a = (cyc == inj); else start_b = (cyc == inj);
      @(negedge clk);
    end
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic check_result(input int which, input int kind, input int faddr, input int fbit,
                              input int n, input int cyc);
    int cnt, ea, ee;
    ref_run(kind, faddr, fbit, n, cnt, ea, ee);
    check("busy_cycles", cyc, 6 + 10 * n + 2);
    check("done", (which == 0) ? done_a : done_b, 1);
    check("busy_low", (which == 0) ? busy_a : busy_b, 0);
    check("fail", (which == 0) ? fail_a : fail_b, cnt != 0);
    check("fail_count", (which == 0) ? fail_count_a : fail_count_b, cnt);
    if (cnt != 0) begin
      check("fail_addr", (which == 0) ? {4'b0, fail_addr_a} : fail_addr_b, ea);
      check("fail_elem", (which == 0) ? fail_elem_a : fail_elem_b, ee);
    end
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_done"}, done_a, 0);
    check({tag, "_fail"}, fail_a, 0);
    check({tag, "_fcount"}, fail_count_a, 0);
    check({tag, "_faddr"}, fail_addr_a, 0);
    check({tag, "_felem"}, fail_elem_a, 0);
    check({tag, "_wr"}, mem_a_if.write_read, 0);
    check({tag, "_addr"}, mem_a_if.address, 0);
    check({tag, "_wdata"}, mem_a_if.wdata, 0);
  endtask

  initial begin
    int cyc, inj, lim;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_a("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Fault-free run with full bus trace.
    obs.delete();
    run(0, -1, 1'b1, cyc);
    check_result(0, 0, 0, 0, 4, cyc);
    build_trace(4);
    check("trace_len", obs.size(), expq.size());
    lim = (obs.size() < expq.size()) ? obs.size() : expq.size();
    for (int i = 0; i < lim; i++) begin
      check($sformatf("trace%0d_op", i), {obs[i].wr, 8'(obs[i].addr)}, {expq[i].wr, 8'(expq[i].addr)});
      if (expq[i].chk_wd) check($sformatf("trace%0d_wdata", i), obs[i].wd, expq[i].wd);
    end

    // Directed faults.
    fa_kind = 1; fa_addr = 2; fa_bit = 0;
    run(0, -1, 1'b0, cyc);
    check_result(0, 1, 2, 0, 4, cyc);
    check("sa0_elem_const", fail_elem_a, 2);
    check("sa0_count_const", fail_count_a, 2);
    fa_kind = 2; fa_addr = 1; fa_bit = 0;
    run(0, -1, 1'b0, cyc);
    check_result(0, 2, 1, 0, 4, cyc);
    check("sa1_count_const", fail_count_a, 3);

    // Reset during M2 after a failure has been captured.
    fa_kind = 1; fa_addr = 2;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (22) @(negedge clk);
    check("pre_reset_fail", fail_a, 1);
    rst_n = 1'b0;
    #1 check_zero_a("midreset");
    repeat (2) @(negedge clk);
    check_zero_a("midreset_hold");
    rst_n = 1'b1; fa_kind = 0;
    @(negedge clk);
    check("post_reset_done", done_a, 0);
    run(0, -1, 1'b0, cyc);
    check_result(0, 0, 0, 0, 4, cyc);

    // Random faults with a stray start pulse during the run.
    for (int r = 0; r < 6; r++) begin
      fa_kind = $urandom_range(0, 2);
      fa_addr = $urandom_range(0, 3);
      fa_bit  = $urandom_range(0, 7);
      inj     = $urandom_range(2, 45);
      run(0, inj, 1'b0, cyc);
      check_result(0, fa_kind, fa_addr, fa_bit, 4, cyc);
    end

    // 300 mismatches on the 60-word instance: counter must saturate.
    fb_kind = 3;
    inj = $urandom_range(50, 550);
    run(1, inj, 1'b0, cyc);
    check_result(1, 3, 0, 0, 60, cyc);
    check("sat_count_const", fail_count_b, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
- March C- BIST engine that drives the single-port test memory interface: write_read, address, wdata out; rdata in.
- Sequences the six March C- elements over addresses 0..LAST_ADDR, compares every read against its expected background, and reports pass/fail, first failing address/element and a saturating mismatch count.
- Sits between the test top-level and the memory model under test.

Parameters:
- DATA_WIDTH, 8, memory word width.
- ADDR_WIDTH, 4, memory address width.
- LAST_ADDR, 2**ADDR_WIDTH-1, highest address tested; N = LAST_ADDR+1.
- RD_LATENCY, 2, cycles from read address issue (sampled edge) to rdata valid.
- CNT_WIDTH, 8, width of fail_count.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; starts a test when idle.
- write_read  out  1  1 = write, 0 = read.
- address  out  ADDR_WIDTH  memory address.
- wdata  out  DATA_WIDTH  write data; memory captures it one cycle before using it.
- rdata  in  DATA_WIDTH  read data, valid RD_LATENCY cycles after issue.
- busy  out  1  test in progress.
- done  out  1  test finished; held until next start.
- fail  out  1  at least one mismatch; sticky until next start.
- fail_addr  out  ADDR_WIDTH  address of first mismatch.
- fail_elem  out  3  March element (0..5) of first mismatch.
- fail_count  out  CNT_WIDTH  mismatch count, saturates at all-ones.

Behaviour:
- Reset: all outputs are 0, FSM is IDLE, compare pipeline is cleared. Reset mid-test aborts immediately with no partial done.
- Elements:
  - M0 up (w0)
  - M1 up (r0,w1)
  - M2 up (r1,w0)
  - M3 down (r0,w1)
  - M4 down (r1,w0)
  - M5 up (r0)
- Backgrounds: 0 = all zeros, 1 = all ones.
- FSM states IDLE -> SETUP -> RUN -> (SETUP of next element | DRAIN) -> DONE -> IDLE on start.
- IDLE:
  - start=1 clears done/fail/fail_count/fail_addr/fail_elem, sets busy, and goes to SETUP with elem=0.
  - start while busy is ignored.
- SETUP (1 cycle per element):
  - write_read=0; address = first address of the element (0 for up, LAST_ADDR for down).
  - wdata = element's write background. This is the one-cycle wdata lead the memory requires.
  - This read is not compared.
- RUN:
  - One operation per cycle; wdata held constant for the whole element.
  - Per address: the element's ops in order (read then write), then address steps +1 (up) or -1 (down).
  - Last op at the end address: go to SETUP of the next element, or to DRAIN after M5.
  - No wrap-around; addresses never exceed LAST_ADDR.
- Compare pipeline: RD_LATENCY-deep shift of {valid, expected, address, elem}, loaded on every RUN read. When the tail is valid, rdata != expected triggers:
  - fail_count++ (saturating).
  - If fail was 0: capture fail_addr and fail_elem, and set fail.
- DRAIN: RD_LATENCY cycles with write_read=0 and address held, letting the final reads retire.
- DONE: busy=0, done=1.
- Total busy time is exactly 6 + 10*N + RD_LATENCY cycles.
- Outputs write_read/address/wdata are registered.

Decomposition:
- Package mbist_pkg holds:
  - elem_t enum (M0..M5).
  - state_t enum (IDLE, SETUP, RUN, DRAIN, DONE).
  - Per-element constant tables: direction, op count, read background, write background.
- One sub-module, mbist_rd_cmp: RD_LATENCY-deep expected-data pipeline plus comparator and fail capture.

Test Plan:
- Fault-free memory, ADDR_WIDTH=2, LAST_ADDR=3, DATA_WIDTH=8 -> busy high exactly 48 cycles, then done=1, fail=0, fail_count=0.
- Same setup, trace check -> M0 writes 0x00 to addresses 0..3. M3 issues r0/w1 pairs at 3,2,1,0 with wdata=0xFF. wdata equals the element background in every SETUP cycle.
- Bench memory with address 2 stuck-at-0 -> fail=1, fail_addr=2, fail_elem=2, fail_count=2 (M2 and M4 read 1).
- Bench memory with bit 0 of address 1 stuck-at-1 -> fail_addr=1, fail_elem=1, fail_count=3 (M1, M3, M5).
- Assert rst_n=0 during M2, then release and pulse start -> all outputs 0 during reset. The new run completes in 48 cycles with a clean result.
- start pulsed mid-RUN, and 300 mismatches with CNT_WIDTH=8 -> the start is ignored; fail_count saturates at 255.
